// File: rtl/fib_seq_ctrl_if.sv
// fib_seq_ctrl_if: register-file port bundle between sequencer and file.
// master drives addresses/write data, slave returns the two read words.
interface fib_seq_ctrl_if #(
   parameter int DATA_W = 8
);
   logic [4:0]        rf_rs;
   logic [4:0]        rf_rt;
   logic [15:0]       rf_out1;
   logic [15:0]       rf_out2;
   logic [1:0]        rf_rd;
   logic [DATA_W-1:0] rf_wdata;
   logic              rf_we;

   modport master (
      output rf_rs,
      output rf_rt,
      output rf_rd,
      output rf_wdata,
      output rf_we,
      input  rf_out1,
      input  rf_out2
   );

   modport slave (
      input  rf_rs,
      input  rf_rt,
      input  rf_rd,
      input  rf_wdata,
      input  rf_we,
      output rf_out1,
      output rf_out2
   );
endinterface

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: drives a 4-entry register file to compute Fibonacci F(n).
// Define FIB_OVF_STOP_EN to stop on adder carry and flag overflow.
module fib_seq_ctrl #(
   parameter int DATA_W = 8,
   parameter int N_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [N_W-1:0]    n_in_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o,
   output logic              overflow_o,
   fib_seq_ctrl_if.master    rf
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT0,
      S_INIT1,
      S_CALC,
      S_MOV0,
      S_MOV1,
      S_FIN
   } state_e;

   state_e state_q, state_d;

   logic [N_W-1:0]    iter_q, iter_d;
   logic              nzero_q, nzero_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              ovf_q, ovf_d;
   logic              overflow_q, overflow_d;

   logic [DATA_W-1:0] a_w, b_w, sum_w;
   logic              carry_w;

   assign a_w = rf.rf_out1[DATA_W-1:0];
   assign b_w = rf.rf_out2[DATA_W-1:0];

`ifdef FIB_OVF_STOP_EN
   logic [DATA_W:0] sum_full_w;
   assign sum_full_w = {1'b0, a_w} + {1'b0, b_w};
   assign sum_w      = sum_full_w[DATA_W-1:0];
   assign carry_w    = sum_full_w[DATA_W];
`else
   assign sum_w   = a_w + b_w;
   assign carry_w = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_i) state_d = S_INIT0;
         S_INIT0: state_d = S_INIT1;
         S_INIT1: state_d = (iter_q == '0) ? S_FIN : S_CALC;
         S_CALC:  state_d = carry_w ? S_FIN : S_MOV0;
         S_MOV0:  state_d = S_MOV1;
         S_MOV1:  state_d = (iter_q == N_W'(1)) ? S_FIN : S_CALC;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Read ports are combinational, so each step reads and writes in one cycle.
   always_comb begin
      rf.rf_rs    = '0;
      rf.rf_rt    = '0;
      rf.rf_rd    = '0;
      rf.rf_wdata = '0;
      rf.rf_we    = 1'b0;
      unique case (state_q)
         S_INIT0: begin
            rf.rf_rd = 2'd0;
            rf.rf_we = 1'b1;
         end
         S_INIT1: begin
            rf.rf_rd    = 2'd1;
            rf.rf_wdata = DATA_W'(1);
            rf.rf_we    = 1'b1;
         end
         S_CALC: begin
            rf.rf_rs    = 5'd0;
            rf.rf_rt    = 5'd1;
            rf.rf_rd    = 2'd2;
            rf.rf_wdata = sum_w;
            rf.rf_we    = ~carry_w;
         end
         S_MOV0: begin
            rf.rf_rs    = 5'd1;
            rf.rf_rd    = 2'd0;
            rf.rf_wdata = a_w;
            rf.rf_we    = 1'b1;
         end
         S_MOV1: begin
            rf.rf_rs    = 5'd2;
            rf.rf_rd    = 2'd1;
            rf.rf_wdata = a_w;
            rf.rf_we    = 1'b1;
         end
         S_FIN: begin
            rf.rf_rs = nzero_q ? 5'd0 : 5'd1;
         end
         default: ;
      endcase
   end

   always_comb begin
      iter_d     = iter_q;
      nzero_d    = nzero_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;
      ovf_d      = ovf_q;
      overflow_d = overflow_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               iter_d     = (n_in_i == '0) ? '0 : n_in_i - N_W'(1);
               nzero_d    = (n_in_i == '0);
               busy_d     = 1'b1;
               ovf_d      = 1'b0;
               overflow_d = 1'b0;
            end
         end
         S_CALC: begin
            if (carry_w) ovf_d = 1'b1;
         end
         S_MOV1: begin
            iter_d = iter_q - N_W'(1);
         end
         S_FIN: begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            result_d   = ovf_q ? '1 : a_w;
            overflow_d = ovf_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iter_q     <= '0;
         nzero_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         iter_q     <= iter_d;
         nzero_q    <= nzero_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
         ovf_q      <= ovf_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign result_o   = result_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: directed runs of the Fibonacci sequencer against
// a Fibonacci-level reference model and a behavioural register file.
module tb_fib_seq_ctrl;

`ifdef FIB_OVF_STOP_EN
   localparam bit OVF_MODE = 1'b1;
   localparam logic [7:0] RES14 = 8'hFF;
`else
   localparam bit OVF_MODE = 1'b0;
   localparam logic [7:0] RES14 = 8'd121;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start_i = 1'b0;
   logic [7:0] n_in_i = '0;
   logic       busy_o, done_o, overflow_o;
   logic [7:0] result_o;

   fib_seq_ctrl_if #(.DATA_W(8)) rf ();

   fib_seq_ctrl #(.DATA_W(8), .N_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start_i),
      .n_in_i     (n_in_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .overflow_o (overflow_o),
      .rf         (rf)
   );

   always #5 clk = ~clk;

   logic [15:0] regs [4];
   assign rf.rf_out1 = regs[rf.rf_rs[1:0]];
   assign rf.rf_out2 = regs[rf.rf_rt[1:0]];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (rf.rf_we) begin
         regs[rf.rf_rd] <= {8'h00, rf.rf_wdata};
      end
   end

   int total = 0;
   int bad = 0;

   logic [9:0] exp_q [$];
   logic [7:0] exp_res;
   bit         exp_ovf;
   int         exp_lat;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Fibonacci-level model: expected write trace, result, flag, latency.
   task automatic model(input int n);
      int a, b, s;
      exp_q.delete();
      exp_q.push_back({2'd0, 8'd0});
      exp_q.push_back({2'd1, 8'd1});
      a = 0;
      b = 1;
      exp_ovf = 1'b0;
      exp_lat = 3 + 3 * ((n > 1) ? n - 1 : 0);
      for (int k = 2; k <= n; k++) begin
         s = a + b;
         if (OVF_MODE && s > 255) begin
            exp_ovf = 1'b1;
            exp_lat = 4 + 3 * (k - 2);
            break;
         end
         s = s % 256;
         exp_q.push_back({2'd2, 8'(s)});
         exp_q.push_back({2'd0, 8'(b)});
         exp_q.push_back({2'd1, 8'(s)});
         a = b;
         b = s;
      end
      exp_res = exp_ovf ? 8'hFF : ((n == 0) ? 8'd0 : 8'(b));
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (!busy_o) chk("we_idle", 32'(rf.rf_we), 32'd0);
         if (rf.rf_we) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_write: rd=%0d data=%0h",
                        rf.rf_rd, rf.rf_wdata);
            end else begin
               chk("write", 32'({rf.rf_rd, rf.rf_wdata}),
                   32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic launch(input int n);
      model(n);
      start_i = 1'b1;
      n_in_i  = n[7:0];
      @(posedge clk);
      #1;
      start_i = 1'b0;
      chk("busy_after_accept", 32'(busy_o), 32'd1);
   endtask

   task automatic wait_done(input logic [7:0] lit, input bit pulse);
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         cnt++;
         start_i = 1'b0;
         if (done_o) break;
         if (cnt > 400) begin
            total++;
            bad++;
            $display("FAIL timeout: no done after %0d cycles", cnt);
            return;
         end
         if (pulse && (cnt % 4 == 1 || cnt == exp_lat - 1)) begin
            start_i = 1'b1;
            n_in_i  = 8'd3;
         end
      end
      chk("latency", 32'(cnt), 32'(exp_lat));
      chk("result_model", 32'(result_o), 32'(exp_res));
      chk("result_lit", 32'(result_o), 32'(lit));
      chk("overflow", 32'(overflow_o), 32'(exp_ovf));
      chk("busy_at_done", 32'(busy_o), 32'd0);
      chk("writes_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic after_done(input logic [7:0] lit);
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(done_o), 32'd0);
      chk("result_hold", 32'(result_o), 32'(lit));
      chk("busy_idle", 32'(busy_o), 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_result", 32'(result_o), 32'd0);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
      chk("rst_we", 32'(rf.rf_we), 32'd0);
      chk("rst_addr", 32'({rf.rf_rs, rf.rf_rt, rf.rf_rd}), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      launch(13);
      wait_done(8'd233, 1'b0);
      after_done(8'd233);

      launch(10);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_done", 32'(done_o), 32'd0);
      chk("midrst_result", 32'(result_o), 32'd0);
      chk("midrst_we", 32'(rf.rf_we), 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      launch(5);
      wait_done(8'd5, 1'b0);
      after_done(8'd5);

      @(negedge clk);
      launch(0);
      wait_done(8'd0, 1'b0);
      after_done(8'd0);
      @(negedge clk);
      launch(1);
      wait_done(8'd1, 1'b0);
      after_done(8'd1);

      @(negedge clk);
      launch(14);
      wait_done(RES14, 1'b0);
      after_done(RES14);

      @(negedge clk);
      launch(7);
      wait_done(8'd13, 1'b1);
      launch(6);
      wait_done(8'd8, 1'b0);
      after_done(8'd8);

      repeat (3) @(negedge clk);
      launch(2);
      wait_done(8'd1, 1'b0);
      after_done(8'd1);
      launch(3);
      wait_done(8'd2, 1'b0);
      after_done(8'd2);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
